id_stage: RTL and testbench

- Instruction-decode pipeline stage between instruction fetch and the execute/ALU stage of the MIPS core.
- Decodes the opcodes and function codes defined in the core's instruction-constant package into control signals, register ids, ALU operation and extended immediates.
- Holds the result in a valid/ready pipeline register.
- Inserts one bubble on load-use hazards and discards its contents on a branch/jump flush.

---
 rtl/id_stage.sv | 286 ++++++++++++++++++++++++++++
 tb/tb_id_stage.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/id_stage.sv
// rtl/id_stage.sv - MIPS instruction-decode stage with valid/ready output register, load-use bubble and flush.
// Optional build macro MIPS_ILLEGAL_TRAP_EN: undefined opcodes/functs raise ex_illegal instead of decoding as NOP.
module id_stage #(
    parameter int PC_W    = 32,
    parameter int ALUOP_W = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               if_valid,
    input  logic [31:0]        if_instr,
    input  logic [PC_W-1:0]    if_pc,
    output logic               if_ready,
    input  logic               flush,
    input  logic               ex_ready,
    output logic               ex_valid,
    output logic [PC_W-1:0]    ex_pc,
    output logic [ALUOP_W-1:0] ex_aluop,
    output logic               ex_alu_unsigned,
    output logic               ex_alu_arith,
    output logic               ex_ovf_trap,
    output logic [4:0]         ex_rs,
    output logic [4:0]         ex_rt,
    output logic [4:0]         ex_dest,
    output logic               ex_reg_write,
    output logic               ex_use_imm,
    output logic [31:0]        ex_imm,
    output logic [4:0]         ex_shamt,
    output logic               ex_shift_var,
    output logic               ex_mem_read,
    output logic               ex_mem_write,
    output logic [1:0]         ex_branch,
    output logic [1:0]         ex_jump,
    output logic [PC_W-1:0]    ex_jtarget,
    output logic               ex_illegal
);

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_SLTIU = 6'h0B;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_XORI  = 6'h0E;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_SLL  = 6'h00;
    localparam logic [5:0] FN_SRL  = 6'h02;
    localparam logic [5:0] FN_SRA  = 6'h03;
    localparam logic [5:0] FN_SLLV = 6'h04;
    localparam logic [5:0] FN_SRLV = 6'h06;
    localparam logic [5:0] FN_SRAV = 6'h07;
    localparam logic [5:0] FN_JR   = 6'h08;
    localparam logic [5:0] FN_ADD  = 6'h20;
    localparam logic [5:0] FN_ADDU = 6'h21;
    localparam logic [5:0] FN_SUB  = 6'h22;
    localparam logic [5:0] FN_SUBU = 6'h23;
    localparam logic [5:0] FN_AND  = 6'h24;
    localparam logic [5:0] FN_OR   = 6'h25;
    localparam logic [5:0] FN_XOR  = 6'h26;
    localparam logic [5:0] FN_NOR  = 6'h27;
    localparam logic [5:0] FN_SLT  = 6'h2A;
    localparam logic [5:0] FN_SLTU = 6'h2B;

    localparam logic [ALUOP_W-1:0] ALU_ADD = ALUOP_W'(0);
    localparam logic [ALUOP_W-1:0] ALU_SUB = ALUOP_W'(1);
    localparam logic [ALUOP_W-1:0] ALU_CMP = ALUOP_W'(2);
    localparam logic [ALUOP_W-1:0] ALU_AND = ALUOP_W'(3);
    localparam logic [ALUOP_W-1:0] ALU_OR  = ALUOP_W'(4);
    localparam logic [ALUOP_W-1:0] ALU_XOR = ALUOP_W'(5);
    localparam logic [ALUOP_W-1:0] ALU_NOR = ALUOP_W'(6);
    localparam logic [ALUOP_W-1:0] ALU_SL  = ALUOP_W'(7);
    localparam logic [ALUOP_W-1:0] ALU_SR  = ALUOP_W'(8);

    typedef struct packed {
        logic [PC_W-1:0]    pc;
        logic [ALUOP_W-1:0] aluop;
        logic               alu_unsigned;
        logic               alu_arith;
        logic               ovf_trap;
        logic [4:0]         rs;
        logic [4:0]         rt;
        logic [4:0]         dest;
        logic               reg_write;
        logic               use_imm;
        logic [31:0]        imm;
        logic [4:0]         shamt;
        logic               shift_var;
        logic               mem_read;
        logic               mem_write;
        logic [1:0]         branch;
        logic [1:0]         jump;
        logic [PC_W-1:0]    jtarget;
        logic               illegal;
    } dec_t;

    dec_t            dec;
    dec_t            ex_r;
    logic            ex_v;
    logic            reads_rs;
    logic            reads_rt;
    logic            legal;
    logic            hazard;
    logic            load_en;
    logic            accept;
    logic [5:0]      opcode;
    logic [5:0]      funct;
    logic [15:0]     imm16;
    logic [31:0]     imm_sext;
    logic [31:0]     imm_zext;
    logic [PC_W-1:0] pc_plus4;

    assign opcode   = if_instr[31:26];
    assign funct    = if_instr[5:0];
    assign imm16    = if_instr[15:0];
    assign imm_sext = {{16{imm16[15]}}, imm16};
    assign imm_zext = {16'h0000, imm16};
    assign pc_plus4 = if_pc + PC_W'(4);

    always_comb begin
        dec      = '0;
        reads_rs = 1'b0;
        reads_rt = 1'b0;
        legal    = 1'b1;
        dec.pc   = if_pc;
        dec.rs   = if_instr[25:21];
        dec.rt   = if_instr[20:16];

        case (opcode)
            OP_RTYPE: begin
                dec.dest      = if_instr[15:11];
                dec.reg_write = 1'b1;
                reads_rs      = 1'b1;
                reads_rt      = 1'b1;
                case (funct)
                    FN_SLL:  begin dec.aluop = ALU_SL; dec.shamt = if_instr[10:6]; reads_rs = 1'b0; end
                    FN_SRL:  begin dec.aluop = ALU_SR; dec.shamt = if_instr[10:6]; reads_rs = 1'b0; end
                    FN_SRA:  begin
                        dec.aluop     = ALU_SR;
                        dec.alu_arith = 1'b1;
                        dec.shamt     = if_instr[10:6];
                        reads_rs      = 1'b0;
                    end
                    FN_SLLV: begin dec.aluop = ALU_SL; dec.shift_var = 1'b1; end
                    FN_SRLV: begin dec.aluop = ALU_SR; dec.shift_var = 1'b1; end
                    FN_SRAV: begin dec.aluop = ALU_SR; dec.shift_var = 1'b1; dec.alu_arith = 1'b1; end
                    FN_JR:   begin dec.jump = 2'd2; dec.reg_write = 1'b0; end
                    FN_ADD:  begin dec.aluop = ALU_ADD; dec.ovf_trap = 1'b1; end
                    FN_ADDU: dec.aluop = ALU_ADD;
                    FN_SUB:  begin dec.aluop = ALU_SUB; dec.ovf_trap = 1'b1; end
                    FN_SUBU: dec.aluop = ALU_SUB;
                    FN_AND:  dec.aluop = ALU_AND;
                    FN_OR:   dec.aluop = ALU_OR;
                    FN_XOR:  dec.aluop = ALU_XOR;
                    FN_NOR:  dec.aluop = ALU_NOR;
                    FN_SLT:  dec.aluop = ALU_CMP;
                    FN_SLTU: begin dec.aluop = ALU_CMP; dec.alu_unsigned = 1'b1; end
                    default: legal = 1'b0;
                endcase
            end
            OP_J, OP_JAL: begin
                // J-format has no source registers; the rs/rt fields belong to the target.
                dec.rs   = 5'd0;
                dec.rt   = 5'd0;
                dec.jump = 2'd1;
                dec.jtarget        = pc_plus4;
                dec.jtarget[27:0]  = {if_instr[25:0], 2'b00};
                if (opcode == OP_JAL) begin
                    dec.dest      = 5'd31;
                    dec.aluop     = ALU_ADD;
                    dec.reg_write = 1'b1;
                end
            end
            OP_BEQ, OP_BNE: begin
                dec.aluop  = ALU_SUB;
                dec.imm    = imm_sext;
                dec.branch = (opcode == OP_BEQ) ? 2'd1 : 2'd2;
                reads_rs   = 1'b1;
                reads_rt   = 1'b1;
            end
            OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU, OP_LW, OP_SW: begin
                dec.imm       = imm_sext;
                dec.use_imm   = 1'b1;
                dec.dest      = if_instr[20:16];
                dec.reg_write = 1'b1;
                reads_rs      = 1'b1;
                case (opcode)
                    OP_ADDI:  begin dec.aluop = ALU_ADD; dec.ovf_trap = 1'b1; end
                    OP_SLTI:  dec.aluop = ALU_CMP;
                    OP_SLTIU: begin dec.aluop = ALU_CMP; dec.alu_unsigned = 1'b1; end
                    OP_LW:    begin dec.aluop = ALU_ADD; dec.mem_read = 1'b1; end
                    OP_SW:    begin
                        dec.aluop     = ALU_ADD;
                        dec.mem_write = 1'b1;
                        dec.reg_write = 1'b0;
                        reads_rt      = 1'b1;
                    end
                    default:  dec.aluop = ALU_ADD;
                endcase
            end
            OP_ORI, OP_XORI: begin
                dec.aluop     = (opcode == OP_ORI) ? ALU_OR : ALU_XOR;
                dec.imm       = imm_zext;
                dec.use_imm   = 1'b1;
                dec.dest      = if_instr[20:16];
                dec.reg_write = 1'b1;
                reads_rs      = 1'b1;
            end
            OP_LUI: begin
                // LUI is OR with $0 so EX needs no dedicated path.
                dec.aluop     = ALU_OR;
                dec.rs        = 5'd0;
                dec.imm       = {imm16, 16'h0000};
                dec.use_imm   = 1'b1;
                dec.dest      = if_instr[20:16];
                dec.reg_write = 1'b1;
                reads_rs      = 1'b1;
            end
            default: legal = 1'b0;
        endcase

        if (dec.dest == 5'd0) begin
            dec.reg_write = 1'b0;
        end

        if (!legal) begin
            dec      = '0;
            dec.pc   = if_pc;
            reads_rs = 1'b0;
            reads_rt = 1'b0;
`ifdef MIPS_ILLEGAL_TRAP_EN
            dec.illegal = 1'b1;
`else
            dec.illegal = 1'b0;
`endif
        end
    end

    assign hazard  = if_valid && ex_v && ex_r.mem_read && (ex_r.dest != 5'd0) &&
                     ((reads_rs && (dec.rs == ex_r.dest)) || (reads_rt && (dec.rt == ex_r.dest)));
    assign load_en = ex_ready || !ex_v;
    assign if_ready = load_en && !hazard && !flush && !rst;
    assign accept  = if_valid && if_ready;

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            ex_v <= 1'b0;
            ex_r <= '0;
        end else if (load_en) begin
            if (accept) begin
                ex_v <= 1'b1;
                ex_r <= dec;
            end else begin
                ex_v <= 1'b0;
                ex_r <= '0;
            end
        end
    end

    assign ex_valid        = ex_v;
    assign ex_pc           = ex_r.pc;
    assign ex_aluop        = ex_r.aluop;
    assign ex_alu_unsigned = ex_r.alu_unsigned;
    assign ex_alu_arith    = ex_r.alu_arith;
    assign ex_ovf_trap     = ex_r.ovf_trap;
    assign ex_rs           = ex_r.rs;
    assign ex_rt           = ex_r.rt;
    assign ex_dest         = ex_r.dest;
    assign ex_reg_write    = ex_r.reg_write;
    assign ex_use_imm      = ex_r.use_imm;
    assign ex_imm          = ex_r.imm;
    assign ex_shamt        = ex_r.shamt;
    assign ex_shift_var    = ex_r.shift_var;
    assign ex_mem_read     = ex_r.mem_read;
    assign ex_mem_write    = ex_r.mem_write;
    assign ex_branch       = ex_r.branch;
    assign ex_jump         = ex_r.jump;
    assign ex_jtarget      = ex_r.jtarget;
    assign ex_illegal      = ex_r.illegal;

endmodule

// File: tb/tb_id_stage.sv
// tb/tb_id_stage.sv - directed self-checking bench for id_stage.
module tb_id_stage;

    logic        clk;
    logic        rst;
    logic        if_valid;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic        if_ready;
    logic        flush;
    logic        ex_ready;
    logic        ex_valid;
    logic [31:0] ex_pc;
    logic [3:0]  ex_aluop;
    logic        ex_alu_unsigned;
    logic        ex_alu_arith;
    logic        ex_ovf_trap;
    logic [4:0]  ex_rs;
    logic [4:0]  ex_rt;
    logic [4:0]  ex_dest;
    logic        ex_reg_write;
    logic        ex_use_imm;
    logic [31:0] ex_imm;
    logic [4:0]  ex_shamt;
    logic        ex_shift_var;
    logic        ex_mem_read;
    logic        ex_mem_write;
    logic [1:0]  ex_branch;
    logic [1:0]  ex_jump;
    logic [31:0] ex_jtarget;
    logic        ex_illegal;

    int n_cmp  = 0;
    int n_fail = 0;

    id_stage #(.PC_W(32), .ALUOP_W(4)) dut (
        .clk(clk), .rst(rst),
        .if_valid(if_valid), .if_instr(if_instr), .if_pc(if_pc), .if_ready(if_ready),
        .flush(flush), .ex_ready(ex_ready), .ex_valid(ex_valid), .ex_pc(ex_pc),
        .ex_aluop(ex_aluop), .ex_alu_unsigned(ex_alu_unsigned), .ex_alu_arith(ex_alu_arith),
        .ex_ovf_trap(ex_ovf_trap), .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_dest(ex_dest),
        .ex_reg_write(ex_reg_write), .ex_use_imm(ex_use_imm), .ex_imm(ex_imm),
        .ex_shamt(ex_shamt), .ex_shift_var(ex_shift_var), .ex_mem_read(ex_mem_read),
        .ex_mem_write(ex_mem_write), .ex_branch(ex_branch), .ex_jump(ex_jump),
        .ex_jtarget(ex_jtarget), .ex_illegal(ex_illegal)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic present(input logic [31:0] instr, input logic [31:0] pc);
        if_valid = 1'b1;
        if_instr = instr;
        if_pc    = pc;
    endtask

    initial begin
        rst = 1'b1; if_valid = 1'b0; if_instr = '0; if_pc = '0; flush = 1'b0; ex_ready = 1'b1;
        tick();
        tick();
        chk("rst_valid", 32'(ex_valid), 32'd0);
        chk("rst_imm", ex_imm, 32'd0);
        chk("rst_dest", 32'(ex_dest), 32'd0);
        rst = 1'b0;
        #1;
        chk("rst_if_ready", 32'(if_ready), 32'd1);

        // ADDI $t0,$t1,-4
        present(32'h2128FFFC, 32'h100);
        tick();
        if_valid = 1'b0;
        chk("addi_valid", 32'(ex_valid), 32'd1);
        chk("addi_pc", ex_pc, 32'h100);
        chk("addi_aluop", 32'(ex_aluop), 32'd0);
        chk("addi_rs", 32'(ex_rs), 32'd9);
        chk("addi_dest", 32'(ex_dest), 32'd8);
        chk("addi_imm", ex_imm, 32'hFFFFFFFC);
        chk("addi_use_imm", 32'(ex_use_imm), 32'd1);
        chk("addi_ovf", 32'(ex_ovf_trap), 32'd1);
        chk("addi_wr", 32'(ex_reg_write), 32'd1);

        // LW $t0,0($s0) then ADD $t2,$t0,$t1 -> one bubble
        present(32'h8E080000, 32'h104);
        tick();
        chk("lw_mem_read", 32'(ex_mem_read), 32'd1);
        chk("lw_dest", 32'(ex_dest), 32'd8);
        present(32'h01095020, 32'h108);
        #1;
        chk("hz_if_ready", 32'(if_ready), 32'd0);
        tick();
        chk("hz_bubble", 32'(ex_valid), 32'd0);
        chk("hz_bubble_ctl", 32'(ex_mem_read), 32'd0);
        chk("hz_release", 32'(if_ready), 32'd1);
        tick();
        if_valid = 1'b0;
        chk("add_valid", 32'(ex_valid), 32'd1);
        chk("add_rs", 32'(ex_rs), 32'd8);
        chk("add_rt", 32'(ex_rt), 32'd9);
        chk("add_dest", 32'(ex_dest), 32'd10);
        chk("add_pc", ex_pc, 32'h108);

        // ORI $t0,$0,0xFFFF held by ex_ready=0 for 3 cycles
        present(32'h3408FFFF, 32'h10C);
        tick();
        ex_ready = 1'b0;
        present(32'h380900F0, 32'h110);
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("stall_if_ready", 32'(if_ready), 32'd0);
            tick();
            chk("stall_valid", 32'(ex_valid), 32'd1);
            chk("stall_imm", ex_imm, 32'h0000FFFF);
            chk("stall_aluop", 32'(ex_aluop), 32'd4);
        end
        ex_ready = 1'b1;
        #1;
        chk("unstall_if_ready", 32'(if_ready), 32'd1);
        tick();
        if_valid = 1'b0;
        chk("xori_imm", ex_imm, 32'h000000F0);
        chk("xori_aluop", 32'(ex_aluop), 32'd5);
        chk("xori_dest", 32'(ex_dest), 32'd9);

        // Flush blocks JAL; then JAL decoded normally
        present(32'h0C400000, 32'h0FFFFFFC);
        flush = 1'b1;
        #1;
        chk("flush_if_ready", 32'(if_ready), 32'd0);
        tick();
        flush = 1'b0;
        if_valid = 1'b0;
        chk("flush_valid", 32'(ex_valid), 32'd0);
        present(32'h0C400000, 32'h0FFFFFFC);
        tick();
        if_valid = 1'b0;
        chk("jal_valid", 32'(ex_valid), 32'd1);
        chk("jal_target", ex_jtarget, 32'h11000000);
        chk("jal_dest", 32'(ex_dest), 32'd31);
        chk("jal_wr", 32'(ex_reg_write), 32'd1);
        chk("jal_jump", 32'(ex_jump), 32'd1);

        // Reserved opcode 6'b111111
        present(32'hFC000000, 32'h200);
        tick();
        if_valid = 1'b0;
        chk("ill_valid", 32'(ex_valid), 32'd1);
        chk("ill_wr", 32'(ex_reg_write), 32'd0);
        chk("ill_memw", 32'(ex_mem_write), 32'd0);
`ifdef MIPS_ILLEGAL_TRAP_EN
        chk("ill_flag", 32'(ex_illegal), 32'd1);
`else
        chk("ill_flag", 32'(ex_illegal), 32'd0);
`endif

        // NOP = SLL $0,$0,0
        present(32'h00000000, 32'h204);
        tick();
        chk("nop_valid", 32'(ex_valid), 32'd1);
        chk("nop_wr", 32'(ex_reg_write), 32'd0);
        chk("nop_aluop", 32'(ex_aluop), 32'd7);

        // SRA $t2,$t1,3
        present(32'h000950C3, 32'h208);
        tick();
        chk("sra_aluop", 32'(ex_aluop), 32'd8);
        chk("sra_arith", 32'(ex_alu_arith), 32'd1);
        chk("sra_shamt", 32'(ex_shamt), 32'd3);
        chk("sra_var", 32'(ex_shift_var), 32'd0);

        // SW $t0,4($s0): no register write
        present(32'hAE080004, 32'h20C);
        tick();
        chk("sw_memw", 32'(ex_mem_write), 32'd1);
        chk("sw_wr", 32'(ex_reg_write), 32'd0);
        chk("sw_imm", ex_imm, 32'h00000004);

        // LUI $t0,0x1234
        present(32'h3C081234, 32'h210);
        tick();
        chk("lui_imm", ex_imm, 32'h12340000);
        chk("lui_rs", 32'(ex_rs), 32'd0);
        chk("lui_aluop", 32'(ex_aluop), 32'd4);

        // Reset while ex_valid=1
        present(32'h2128FFFC, 32'h214);
        rst = 1'b1;
        tick();
        chk("mrst_valid", 32'(ex_valid), 32'd0);
        chk("mrst_pc", ex_pc, 32'd0);
        chk("mrst_imm", ex_imm, 32'd0);
        chk("mrst_dest", 32'(ex_dest), 32'd0);
        rst = 1'b0;
        if_valid = 1'b0;
        #1;
        chk("mrst_if_ready", 32'(if_ready), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
